io_uart_rx: RTL
===============

# io_uart_rx

Memory-mapped UART receiver that sits on the core's IO bus next to the existing UART transmitter and LED register. It deserialises 8N1 frames from the `uart_rx` pin into a small FIFO. Software polls a status word, reads the head byte combinationally, and pops it with an IO write. It is the receive direction of the console link and the read-side responder for the core's `IO_mem_*` port.

## Interface
- `CLK_FREQ_HZ`, default 10_000_000: clk frequency.
- `BAUD_RATE`, default 1_000_000: line rate. `DIV = CLK_FREQ_HZ/BAUD_RATE`, which must be ≥ 4 and even.
- `FIFO_DEPTH`, default 4: receive FIFO entries. Power of two, ≥ 2.
- `clk`  in  1  clock.
- `resetn`  in  1  reset, synchronous, active-low.
- `io_addr`  in  32  core `IO_mem_addr`.
- `io_wdata`  in  32  core `IO_mem_wdata`.
- `io_wr`  in  1  core `IO_mem_wr`, a single-cycle write strobe.
- `io_rdata`  out  32  read data, ORed into the SoC's `IO_mem_rdata`.
- `uart_rx`  in  1  asynchronous serial input. Idle high.
- `rx_valid`  out  1  FIFO not empty (status bit 0).

## Operation
- Register decode: selected only when `io_addr[22]=1`. Word address is `io_addr[15:2]`, one-hot decoded.
  - bit 3 = RXDATA (0x400020).
  - bit 4 = RXSTAT (0x400040).
- `io_rdata` is combinational:
  - RXDATA: `{24'b0, head}`. Reads 0 when empty.
  - RXSTAT: `{29'b0, frame_err, overrun, rx_valid}`.
  - Otherwise: 0.
- Pop: `io_wr` to RXDATA pops one entry; `io_wdata` is ignored. Pop when empty is ignored.
- Flag clear: `io_wr` to RXSTAT clears `overrun` if `io_wdata[1]` is set and `frame_err` if `io_wdata[2]` is set.
- Input sync: two flops on `uart_rx`, both reset to 1. The output is `rx_s`.
- FSM, with down-counter `cnt` and bit index `idx[2:0]`:
  - IDLE: when `rx_s=0`, go to START with `cnt=DIV/2-1`.
  - START: decrement `cnt`. At `cnt=0`:
    - if `rx_s=0`, go to DATA with `cnt=DIV-1`, `idx=0`;
    - else return to IDLE (glitch, nothing recorded).
  - DATA: at `cnt=0`, shift `rx_s` in LSB-first and reload `cnt=DIV-1`. When `idx=7`, go to STOP; otherwise increment `idx`.
  - STOP: at `cnt=0`, return to IDLE.
    - If `rx_s=1`, push the byte. If the FIFO is full and no pop occurs that cycle, drop the byte and set `overrun`.
    - If `rx_s=0`, set `frame_err` and discard the byte.
- Simultaneous events:
  - push and pop in the same cycle: both occur and the count is unchanged. When full, the pop frees space first, so there is no overrun.
  - flag set and flag clear in the same cycle: set wins.
- Counters and pointers wrap modulo `FIFO_DEPTH`. The count is `$clog2(FIFO_DEPTH)+1` bits.

## Timing
- Reset (synchronous):
  - FSM returns to IDLE; `cnt`, `idx` and the shift register are 0.
  - FIFO is empty; `overrun` and `frame_err` are 0.
  - Sync flops are 1.
  - Outputs: `rx_valid=0`. `io_rdata` is 0 at RXDATA and at RXSTAT (combinational reads of the cleared state).
- Reset mid-frame aborts the frame. No partial byte is pushed.
- Frame timing: let edge k be the first clk edge that samples the pin low.
  - START entered at edge k+2.
  - Start bit validated at edge k+2+DIV/2.
  - Data bit i sampled at edge k+2+DIV/2+(i+1)·DIV.
  - Stop bit checked, and the byte pushed, at edge k+2+DIV/2+9·DIV. This is k+97 for the defaults.
- `rx_valid` and the RXDATA/RXSTAT contents change on the edge after the push or pop.
- Back-to-back frames: the FSM is in IDLE half a bit before the nominal stop-bit end, so a start bit immediately following is caught.

## Structure
- Shared header `io_map.vh` holds:
  - IO select bit 22;
  - word-decode bit indices for LEDS(0), UART_TX_DATA(1), UART_TX_STAT(2), UART_RX_DATA(3), UART_RX_STAT(4);
  - RXSTAT bit positions;
  - the FSM state localparams (IDLE/START/DATA/STOP).
- One sub-module, `sync_fifo`:
  - parameters WIDTH=8 and DEPTH;
  - ports push/pop/din/dout/empty/full;
  - dout is combinational from the head.

## Test plan
1. Reset: hold `resetn=0` for 3 cycles → `rx_valid=0`, RXSTAT reads 0x0, RXDATA reads 0x0.
2. Single byte: drive 0x55 at 10 clk/bit → `rx_valid` rises exactly 97 cycles after edge k. RXDATA=0x00000055, RXSTAT=0x1. Write RXDATA → RXSTAT=0x0 next cycle.
3. Overrun: send 0x01..0x05 back-to-back with no pops → RXSTAT=0x3. Four pops read 0x01,0x02,0x03,0x04, then empty. Write RXSTAT 0x2 → RXSTAT=0x0.
4. Frame error: 0xA5 with stop bit low → RXSTAT=0x4, FIFO empty. Next good 0x5A is received. Write 0x4 clears the flag.
5. Glitch and push/pop collision: pin low for 3 cycles → nothing pushed. With the FIFO full, pop in the same cycle as a push of 0x77 → no overrun, 0x77 at the tail.
6. Reset mid-frame: assert `resetn=0` during DATA bit 4 → FIFO empty, flags 0. A following full 0x3C frame reads back 0x3C.

Source files
------------

// File: rtl/io_uart_rx_pkg.sv
// Shared IO map, receiver state encoding and status layout for the UART receive port.
package io_uart_rx_pkg;

  localparam int unsigned IO_SEL_BIT  = 22;
  localparam int unsigned IO_WORD_LSB = 2;

  // One-hot word-address bit for each IO register
  localparam int unsigned IO_W_LEDS         = 0;
  localparam int unsigned IO_W_UART_TX_DATA = 1;
  localparam int unsigned IO_W_UART_TX_STAT = 2;
  localparam int unsigned IO_W_UART_RX_DATA = 3;
  localparam int unsigned IO_W_UART_RX_STAT = 4;

  localparam int unsigned RX_BYTE_W = 8;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

  // RXSTAT payload, LSB first: valid, overrun, frame_err
  typedef struct packed {
    logic frame_err;
    logic overrun;
    logic valid;
  } rx_stat_t;

  function automatic logic io_word_sel(input logic [31:0] addr, input int unsigned word_bit);
    return addr[IO_SEL_BIT] & addr[IO_WORD_LSB + word_bit];
  endfunction

endpackage

// File: rtl/io_uart_rx_sync_fifo.sv
// Small synchronous FIFO; pop frees a slot before push in the same cycle, dout shows the head.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage needs no reset: it is only visible through the pointers
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/io_uart_rx.sv
// Memory-mapped 8N1 UART receiver: pin synchroniser, frame FSM, receive FIFO and status flags.
module io_uart_rx
  import io_uart_rx_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 10_000_000,
  parameter int unsigned BAUD_RATE   = 1_000_000,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [31:0] io_addr,
  input  logic [31:0] io_wdata,
  input  logic        io_wr,
  output logic [31:0] io_rdata,
  input  logic        uart_rx,
  output logic        rx_valid
);

  localparam int unsigned DIV   = CLK_FREQ_HZ / BAUD_RATE;
  localparam int unsigned CNT_W = $clog2(DIV);

  logic [1:0]           sync_q;
  logic                 rx_s;
  rx_state_t            state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2:0]           idx_q, idx_d;
  logic [RX_BYTE_W-1:0] shreg_q, shreg_d;
  logic                 push_req;
  logic                 frame_set;
  logic                 overrun_q;
  logic                 frame_err_q;
  logic                 sel_data;
  logic                 sel_stat;
  logic                 pop_req;
  logic                 stat_wr;
  logic                 ovr_set;
  logic                 fifo_empty;
  logic                 fifo_full;
  logic [RX_BYTE_W-1:0] fifo_dout;
  rx_stat_t             stat;
  logic                 unused_wdata;

  assign unused_wdata = ^{io_wdata[31:3], io_wdata[0]};

  // Two-flop synchroniser, idle-high after reset
  always_ff @(posedge clk) begin
    if (!resetn) sync_q <= 2'b11;
    else         sync_q <= {sync_q[0], uart_rx};
  end
  assign rx_s = sync_q[1];

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= RX_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shreg_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
    end
  end

  // Each state waits for cnt to hit zero, then samples the synchronised pin
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    shreg_d   = shreg_q;
    push_req  = 1'b0;
    frame_set = 1'b0;
    unique case (state_q)
      RX_IDLE: begin
        if (!rx_s) begin
          state_d = RX_START;
          cnt_d   = CNT_W'(DIV / 2 - 1);
        end
      end
      RX_START: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else if (!rx_s) begin
          state_d = RX_DATA;
          cnt_d   = CNT_W'(DIV - 1);
          idx_d   = '0;
        end else begin
          state_d = RX_IDLE;
        end
      end
      RX_DATA: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          shreg_d = {rx_s, shreg_q[RX_BYTE_W-1:1]};
          cnt_d   = CNT_W'(DIV - 1);
          if (idx_q == 3'd7) state_d = RX_STOP;
          else               idx_d   = idx_q + 3'd1;
        end
      end
      RX_STOP: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          state_d   = RX_IDLE;
          push_req  = rx_s;
          frame_set = ~rx_s;
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  assign sel_data = io_word_sel(io_addr, IO_W_UART_RX_DATA);
  assign sel_stat = io_word_sel(io_addr, IO_W_UART_RX_STAT);
  assign pop_req  = io_wr & sel_data;
  assign stat_wr  = io_wr & sel_stat;
  // A full FIFO only overflows when software is not popping in the same cycle
  assign ovr_set  = push_req & fifo_full & ~pop_req;

  sync_fifo #(
    .WIDTH (RX_BYTE_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (push_req),
    .pop    (pop_req),
    .din    (shreg_q),
    .dout   (fifo_dout),
    .empty  (fifo_empty),
    .full   (fifo_full)
  );

  // Sticky flags: a set in the same cycle as a clear wins
  always_ff @(posedge clk) begin
    if (!resetn) begin
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      overrun_q   <= ovr_set   | (overrun_q   & ~(stat_wr & io_wdata[1]));
      frame_err_q <= frame_set | (frame_err_q & ~(stat_wr & io_wdata[2]));
    end
  end

  assign rx_valid = ~fifo_empty;
  assign stat     = '{frame_err: frame_err_q, overrun: overrun_q, valid: ~fifo_empty};

  always_comb begin
    io_rdata = '0;
    if (sel_data && !fifo_empty) io_rdata = io_rdata | 32'(fifo_dout);
    if (sel_stat)                io_rdata = io_rdata | 32'(stat);
  end

endmodule
